// File: rtl/scope_pkg.sv
// rtl/scope_pkg.sv - shared oscilloscope types and default sizes
// Shared by the trigger, waveform_capture and the renderer.
//   capture_state_t      : capture FSM states
//   SCOPE_DATA_WIDTH     : default sample width
//   SCOPE_ADDR_WIDTH     : default capture depth exponent (DEPTH = 2^ADDR_WIDTH)
//   SCOPE_PRE_TRIGGER    : default number of samples kept before the trigger sample
package scope_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } capture_state_t;

    localparam int SCOPE_DATA_WIDTH  = 8;
    localparam int SCOPE_ADDR_WIDTH  = 10;
    localparam int SCOPE_PRE_TRIGGER = 256;

endpackage

// File: rtl/sample_ram.sv
// rtl/sample_ram.sv - simple dual-port sample RAM with registered read
// Ports:
//   clock            : write and read clock
//   reset            : synchronous active-high, clears only the read register
//   wr_en/wr_addr/wr_data : write port
//   rd_addr          : read address, sampled on the rising edge
//   rd_data          : registered read data, one cycle after rd_addr
module sample_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output register reset maps onto the block-RAM output latch reset;
    // the array itself is never cleared.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/waveform_capture.sv
// rtl/waveform_capture.sv - circular pre/post-trigger capture buffer for the scope
// Ports:
//   clock, reset     : system clock, synchronous active-high reset
//   dataIn           : sample stream (same bus as the trigger input)
//   sampleValid      : dataIn carries a new sample this cycle
//   isTriggered      : current sample is the trigger sample
//   triggerDisable   : high whenever the capture is not ARMED
//   rearm            : renderer request for a new capture (honoured in DONE only)
//   captureDone      : buffer frozen and readable
//   readAddress      : logical read index, 0 = oldest, PRE_TRIGGER = trigger sample
//   readData         : registered sample at readAddress
//   triggerAddress   : physical RAM address of the trigger sample
module waveform_capture
    import scope_pkg::*;
#(
    parameter int ADDR_WIDTH  = SCOPE_ADDR_WIDTH,
    parameter int DATA_WIDTH  = SCOPE_DATA_WIDTH,
    parameter int PRE_TRIGGER = SCOPE_PRE_TRIGGER
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic                  sampleValid,
    input  logic                  isTriggered,
    output logic                  triggerDisable,
    input  logic                  rearm,
    output logic                  captureDone,
    input  logic [ADDR_WIDTH-1:0] readAddress,
    output logic [DATA_WIDTH-1:0] readData,
    output logic [ADDR_WIDTH-1:0] triggerAddress
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    // Counters need one extra bit: the post window reaches DEPTH when PRE_TRIGGER = 0.
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]         PRE_CNT  = CW'(PRE_TRIGGER);
    localparam logic [CW-1:0]         POST_CNT = CW'(DEPTH - PRE_TRIGGER);
    localparam logic [ADDR_WIDTH-1:0] PRE_OFF  = ADDR_WIDTH'(PRE_TRIGGER);

    capture_state_t          state, next_state;
    logic [ADDR_WIDTH-1:0]   writeAddress;
    logic [CW-1:0]           fillCount;
    logic [CW-1:0]           postCount;
    logic                    write_en;
    logic                    trigger_hit;
    logic [ADDR_WIDTH-1:0]   read_phys;

    assign trigger_hit = sampleValid && isTriggered;

    // Modulo-DEPTH arithmetic: the subtraction wraps on purpose.
    assign read_phys = triggerAddress - PRE_OFF + readAddress;

    always_comb begin
        next_state = state;
        write_en   = 1'b0;
        case (state)
            FILL: begin
                write_en = sampleValid;
                if (fillCount == PRE_CNT) begin
                    next_state = ARMED;
                end
            end
            ARMED: begin
                write_en = sampleValid;
                if (trigger_hit) begin
                    // A one-sample post window is already complete at the trigger.
                    next_state = (POST_CNT == CW'(1)) ? DONE : POST;
                end
            end
            POST: begin
                write_en = sampleValid;
                // Leave on the edge that writes the last sample, otherwise the
                // next valid sample would overwrite the oldest pre-trigger one.
                if (sampleValid && (postCount + CW'(1) == POST_CNT)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (rearm) begin
                    next_state = FILL;
                end
            end
            default: next_state = FILL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= FILL;
            writeAddress   <= '0;
            fillCount      <= '0;
            postCount      <= '0;
            captureDone    <= 1'b0;
            triggerDisable <= 1'b1;
            triggerAddress <= '0;
        end else begin
            state          <= next_state;
            captureDone    <= (next_state == DONE);
            triggerDisable <= (next_state != ARMED);
            if (write_en) begin
                writeAddress <= writeAddress + ADDR_WIDTH'(1);
            end
            case (state)
                FILL: begin
                    if (sampleValid && (fillCount != PRE_CNT)) begin
                        fillCount <= fillCount + CW'(1);
                    end
                end
                ARMED: begin
                    if (trigger_hit) begin
                        triggerAddress <= writeAddress;
                        postCount      <= CW'(1);
                    end
                end
                POST: begin
                    if (sampleValid) begin
                        postCount <= postCount + CW'(1);
                    end
                end
                DONE: begin
                    if (rearm) begin
                        fillCount <= '0;
                        postCount <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    sample_ram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_sample_ram (
        .clock  (clock),
        .reset  (reset),
        .wr_en  (write_en && !reset),
        .wr_addr(writeAddress),
        .wr_data(dataIn),
        .rd_addr(read_phys),
        .rd_data(readData)
    );

endmodule

// File: tb/tb_waveform_capture.sv
// tb/tb_waveform_capture.sv - self-checking bench for waveform_capture
module tb_waveform_capture;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int PRE   = 4;
    localparam int DEPTH = 16;
    localparam int POSTN = DEPTH - PRE;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] dataIn;
    logic          sampleValid;
    logic          isTriggered;
    logic          triggerDisable;
    logic          rearm;
    logic          captureDone;
    logic [AW-1:0] readAddress;
    logic [DW-1:0] readData;
    logic [AW-1:0] triggerAddress;

    int checks = 0;
    int passed = 0;
    int sc     = 0;

    // Reference model in terms of sample history: every accepted sample is
    // appended; the capture is the 16 samples around the trigger index.
    logic [7:0] hist[$];
    int         n_fill;
    bit         m_armed, m_post, m_done;
    int         trig_idx;

    waveform_capture #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .PRE_TRIGGER(PRE)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .dataIn        (dataIn),
        .sampleValid   (sampleValid),
        .isTriggered   (isTriggered),
        .triggerDisable(triggerDisable),
        .rearm         (rearm),
        .captureDone   (captureDone),
        .readAddress   (readAddress),
        .readData      (readData),
        .triggerAddress(triggerAddress)
    );

    always #5 clock = ~clock;

    task automatic drive_cycle(input bit r, input bit v, input bit t, input bit rr,
                               input logic [7:0] d, input logic [3:0] ra);
        reset       = r;
        sampleValid = v;
        isTriggered = t;
        rearm       = rr;
        dataIn      = d;
        readAddress = ra;
        @(posedge clock);
        if (r) begin
            hist.delete();
            n_fill   = 0;
            m_armed  = 0;
            m_post   = 0;
            m_done   = 0;
            trig_idx = 0;
        end else if (m_done) begin
            if (rr) begin
                m_done = 0;
                n_fill = 0;
            end
        end else begin
            if (v) hist.push_back(d);
            if (m_armed) begin
                if (v && t) begin
                    m_armed  = 0;
                    m_post   = 1;
                    trig_idx = hist.size() - 1;
                end
            end else if (m_post) begin
                if (hist.size() - trig_idx >= POSTN) begin
                    m_post = 0;
                    m_done = 1;
                end
            end else begin
                if (n_fill >= PRE) m_armed = 1;
                if (v) n_fill++;
            end
        end
        #1;
    endtask

    task automatic valid_sample(input bit t);
        drive_cycle(1'b0, 1'b1, t, 1'b0, 8'(sc), 4'd0);
        sc++;
    endtask

    task automatic test_readback(input string name);
        logic [7:0] exp;
        for (int a = 0; a < DEPTH; a++) begin
            // Keep feeding random samples: the frozen buffer must not change.
            drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'($urandom), 4'(a));
            exp = hist[trig_idx - PRE + a];
            checks++;
            if (readData !== exp)
                $display("FAIL %s_readback addr=%0d got=%0d exp=%0d", name, a, readData, exp);
            else passed++;
        end
    endtask

    task automatic test_reset();
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
        checks++; if (triggerDisable !== 1'b1) $display("FAIL reset_td got=%b exp=1", triggerDisable); else passed++;
        checks++; if (captureDone !== 1'b0) $display("FAIL reset_cd got=%b exp=0", captureDone); else passed++;
        checks++; if (triggerAddress !== 4'd0) $display("FAIL reset_taddr got=%0d exp=0", triggerAddress); else passed++;
        checks++; if (readData !== 8'd0) $display("FAIL reset_rdata got=%0d exp=0", readData); else passed++;
        sc = 0;
    endtask

    task automatic test_prefill_gating();
        int first_low = -1;
        for (int i = 1; i <= 8; i++) begin
            valid_sample(i <= 4);
            checks++;
            if (triggerDisable !== (m_armed ? 1'b0 : 1'b1))
                $display("FAIL gating_td cycle=%0d got=%b exp=%b", i, triggerDisable, !m_armed);
            else passed++;
            if (first_low < 0 && triggerDisable === 1'b0) first_low = i;
        end
        checks++; if (first_low != 5) $display("FAIL gating_low_cycle got=%0d exp=5", first_low); else passed++;
        checks++; if (captureDone !== 1'b0) $display("FAIL gating_no_capture got=%b exp=0", captureDone); else passed++;
    endtask

    task automatic test_basic_capture();
        bit seen = 0;
        int last = -1;
        for (int i = 0; i < 100 && !seen; i++) begin
            last = sc;
            valid_sample(sc == 20);
            checks++;
            if (captureDone !== m_done) $display("FAIL basic_cd sample=%0d got=%b exp=%b", last, captureDone, m_done);
            else passed++;
            if (captureDone === 1'b1) seen = 1;
        end
        checks++; if (!seen || last != 31) $display("FAIL basic_done_after got=%0d exp=31", last); else passed++;
        checks++; if (triggerAddress !== 4'd4) $display("FAIL basic_taddr got=%0d exp=4", triggerAddress); else passed++;
        test_readback("basic");
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd4);
        checks++; if (readData !== 8'd20) $display("FAIL basic_addr4 got=%0d exp=20", readData); else passed++;
    endtask

    task automatic test_rearm_freeze();
        int first_low = -1;
        test_readback("freeze");
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 4'd0);
        checks++; if (captureDone !== 1'b0) $display("FAIL rearm_cd got=%b exp=0", captureDone); else passed++;
        checks++; if (triggerDisable !== 1'b1) $display("FAIL rearm_td got=%b exp=1", triggerDisable); else passed++;
        for (int i = 1; i <= 10; i++) begin
            valid_sample(1'b0);
            checks++;
            if (triggerDisable !== (m_armed ? 1'b0 : 1'b1))
                $display("FAIL refill_td cycle=%0d got=%b exp=%b", i, triggerDisable, !m_armed);
            else passed++;
            if (first_low < 0 && triggerDisable === 1'b0) first_low = i;
        end
        checks++; if (first_low != 5) $display("FAIL refill_low_cycle got=%0d exp=5", first_low); else passed++;
    endtask

    task automatic test_wraparound();
        bit seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            valid_sample(hist.size() == 50);
            if (captureDone === 1'b1) seen = 1;
        end
        checks++; if (!seen || !m_done) $display("FAIL wrap_done got=%b exp=1", captureDone); else passed++;
        checks++; if (triggerAddress !== 4'd2) $display("FAIL wrap_taddr got=%0d exp=2", triggerAddress); else passed++;
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
        checks++; if (readData !== 8'd46) $display("FAIL wrap_logical0 got=%0d exp=46", readData); else passed++;
        test_readback("wrap");
    endtask

    task automatic test_gapped();
        bit seen = 0;
        int target;
        logic [7:0] v0;
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 4'd0);
        target = hist.size() + 10;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (i % 2 == 0) begin
                valid_sample(hist.size() == target);
            end else begin
                // Trigger on an invalid cycle must be ignored.
                drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'hEE, 4'd0);
            end
            checks++;
            if (triggerDisable !== (m_armed ? 1'b0 : 1'b1) || captureDone !== m_done)
                $display("FAIL gapped_ctrl cycle=%0d got=%b%b exp=%b%b", i, triggerDisable, captureDone, !m_armed, m_done);
            else passed++;
            if (captureDone === 1'b1) seen = 1;
        end
        checks++; if (!seen) $display("FAIL gapped_timeout got=0 exp=1"); else passed++;
        checks++; if (triggerAddress !== 4'(trig_idx)) $display("FAIL gapped_taddr got=%0d exp=%0d", triggerAddress, trig_idx % 16); else passed++;
        test_readback("gapped");
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
        v0 = readData;
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd15);
        checks++; if (readData !== v0 + 8'd15) $display("FAIL gapped_no_dup got=%0d exp=%0d", readData, v0 + 8'd15); else passed++;
    endtask

    task automatic test_reset_mid_post();
        bit seen = 0;
        int target;
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 4'd0);
        target = hist.size() + 6;
        for (int i = 0; i < 9; i++) valid_sample(hist.size() == target);
        checks++; if (!m_post || triggerDisable !== 1'b1) $display("FAIL midpost_in_post got=%b exp=1", triggerDisable); else passed++;
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
        checks++; if (triggerDisable !== 1'b1) $display("FAIL midpost_td got=%b exp=1", triggerDisable); else passed++;
        checks++; if (captureDone !== 1'b0) $display("FAIL midpost_cd got=%b exp=0", captureDone); else passed++;
        checks++; if (triggerAddress !== 4'd0) $display("FAIL midpost_taddr got=%0d exp=0", triggerAddress); else passed++;
        for (int i = 0; i < 100 && !seen; i++) begin
            valid_sample(hist.size() == 9);
            if (captureDone === 1'b1) seen = 1;
        end
        checks++; if (!seen) $display("FAIL midpost_timeout got=0 exp=1"); else passed++;
        checks++; if (triggerAddress !== 4'd9) $display("FAIL midpost_taddr2 got=%0d exp=9", triggerAddress); else passed++;
        test_readback("midpost");
    endtask

    task automatic test_random();
        for (int round = 0; round < 4; round++) begin
            bit seen = 0;
            drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 4'd0);
            for (int i = 0; i < 400 && !seen; i++) begin
                drive_cycle(1'b0, ($urandom % 4) != 0, ($urandom % 8) == 0,
                            ($urandom % 16) == 0, 8'($urandom), 4'($urandom));
                checks++;
                if (triggerDisable !== (m_armed ? 1'b0 : 1'b1) || captureDone !== m_done)
                    $display("FAIL random_ctrl round=%0d cycle=%0d got=%b%b exp=%b%b",
                             round, i, triggerDisable, captureDone, !m_armed, m_done);
                else passed++;
                if (m_done) seen = 1;
            end
            checks++; if (!seen) $display("FAIL random_timeout round=%0d got=0 exp=1", round); else passed++;
            if (seen) begin
                checks++;
                if (triggerAddress !== 4'(trig_idx))
                    $display("FAIL random_taddr round=%0d got=%0d exp=%0d", round, triggerAddress, trig_idx % 16);
                else passed++;
                test_readback("random");
            end
        end
    endtask

    initial begin
        test_reset();
        test_prefill_gating();
        test_basic_capture();
        test_rearm_freeze();
        test_wraparound();
        test_gapped();
        test_reset_mid_post();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/waveform_capture.md
# waveform_capture

Capture-memory stage directly downstream of the oscilloscope trigger. It continuously writes incoming 8-bit samples into a circular sample RAM. It drives `triggerDisable` so the trigger is armed only once enough pre-trigger history exists. On `isTriggered` it records a fixed post-trigger window, then freezes the buffer and exposes it through a random-access read port for the display/renderer, until the renderer requests a rearm.

## Interface
- `ADDR_WIDTH`, default 10 — buffer depth is DEPTH = 2^ADDR_WIDTH samples.
- `DATA_WIDTH`, default 8 — sample width; must match the trigger's `dataIn`.
- `PRE_TRIGGER`, default 256 — samples retained before the trigger sample; legal range 0 .. DEPTH-1.

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  — system clock; all logic on the rising edge.
- `reset`  in  1  — synchronous, active-high.
- `dataIn`  in  DATA_WIDTH  — sample stream, the same bus that feeds the trigger.
- `sampleValid`  in  1  — a new sample is present on `dataIn` this cycle.
- `isTriggered`  in  1  — from the trigger; qualifies the current sample as the trigger sample.
- `triggerDisable`  out  1  — to the trigger; high whenever the block is not in ARMED.
- `rearm`  in  1  — single-cycle request from the renderer to start a new capture.
- `captureDone`  out  1  — buffer frozen and readable.
- `readAddress`  in  ADDR_WIDTH  — logical index; 0 = oldest sample, PRE_TRIGGER = trigger sample.
- `readData`  out  DATA_WIDTH  — registered sample at `readAddress`.
- `triggerAddress`  out  ADDR_WIDTH  — physical RAM address of the trigger sample (debug).

## Operation
- States: FILL, ARMED, POST, DONE.
- Reset values:
  - state = FILL; `writeAddress` = 0; `fillCount` = 0; `postCount` = 0.
  - `captureDone` = 0, `triggerDisable` = 1, `triggerAddress` = 0, `readData` = 0.
- Write rule:
  - In FILL, ARMED and POST, each cycle with `sampleValid` = 1 writes `dataIn` to RAM[`writeAddress`], then `writeAddress` increments modulo DEPTH. Wrap is natural, with no flag.
  - No write occurs in DONE.
  - Cycles with `sampleValid` = 0 change nothing.
- FILL:
  - `fillCount` counts written samples.
  - When `fillCount` reaches PRE_TRIGGER, go to ARMED on the next edge. With PRE_TRIGGER = 0, leave FILL on the first edge after entry, with no write required.
  - `isTriggered` is ignored in FILL.
- ARMED:
  - `triggerDisable` = 0.
  - On `sampleValid` = 1 with `isTriggered` = 1: the sample is written, `triggerAddress` is loaded with the current `writeAddress`, `postCount` is set to 1, and the state goes to POST.
  - `isTriggered` with `sampleValid` = 0 is ignored.
- POST:
  - Each valid sample increments `postCount`.
  - When `postCount` reaches DEPTH-PRE_TRIGGER (the trigger sample counts toward this), go to DONE.
- DONE:
  - `captureDone` = 1; RAM is frozen.
  - `rearm` = 1 clears `fillCount`, `captureDone` and `postCount`, and goes to FILL. `writeAddress` is not reset.
  - `rearm` in any other state is ignored.
- Read port:
  - Physical address = (`triggerAddress` − PRE_TRIGGER + `readAddress`) mod DEPTH, computed in ADDR_WIDTH bits with intentional wrap.
  - `readData` is valid in all states, but the contents are only meaningful while `captureDone` = 1.
- Reset asserted in any state returns to FILL at the next edge. RAM contents are not cleared.

## Timing
- `readData` has a latency of 1 cycle from `readAddress`, registered in the synchronous RAM read.
- `triggerDisable` and `captureDone` are registered state decodes and change on the edge after the transition condition.
- Trigger to `captureDone`: `captureDone` rises on the edge following the (DEPTH-PRE_TRIGGER)-th valid sample counted from the trigger sample.
- `rearm` to `triggerDisable` low: at least PRE_TRIGGER valid samples plus 1 cycle, because the FILL → ARMED transition takes one edge.
- `rearm` asserted on the same edge as `captureDone` rising is honoured only from DONE, i.e. the renderer must wait for `captureDone` = 1.

## Structure
- A shared package `scope_pkg` holds:
  - the state enum: FILL, ARMED, POST, DONE;
  - the default sample width and depth constants, which are shared with the trigger and renderer.
- One sub-module, `sample_ram`: a simple dual-port RAM with a write port and a registered read port, inferred as block RAM.
- FSM, counters and address arithmetic live in `waveform_capture`.

## Test plan
All scenarios use ADDR_WIDTH = 4 (DEPTH 16) and PRE_TRIGGER = 4, with `dataIn` = a sample counter 0, 1, 2, … and `sampleValid` high every cycle unless stated.
- Pre-fill gating: after reset, pulse `isTriggered` while in FILL → no capture; `triggerDisable` stays 1 for exactly 4 samples + 1 cycle, then drops to 0.
- Basic capture: trigger on sample 20 → `captureDone` rises after sample 31; reading addresses 0..15 returns 16..31, and address 4 returns 20.
- Wrap-around: trigger at `writeAddress` = 2 → `triggerAddress` = 2; logical 0 maps to physical 14; the full readback is contiguous and in order.
- Gapped samples: `sampleValid` toggling 1/0 → the count advances only on valid cycles; `isTriggered` on an invalid cycle is ignored; the capture contains no duplicated samples.
- Rearm and freeze: in DONE, keep driving `dataIn` → readback unchanged. Pulse `rearm` → `captureDone` = 0 next cycle, FILL refills 4 samples, and a second capture is correct.
- Reset mid-POST: assert `reset` 3 samples after the trigger → state FILL, `captureDone` 0, `triggerDisable` 1, and a subsequent capture is correct.
